boot_loader: RTL and testbench

- Upstream of the single-cycle core: fills instruction memory from a byte stream (UART RX output) before the core runs.
- Parses a framed image (header, word count, payload, checksum), assembles little-endian 32-bit words and drives the IMEM write port.
- Holds the core in reset until a valid frame has been loaded, then releases it.
- On a bad frame it latches an error and keeps the core in reset.

---
 rtl/boot_pkg.sv | 19 +
 rtl/word_assembler.sv | 40 ++++
 rtl/boot_loader.sv | 160 ++++++++++++++++
 tb/tb_boot_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding, frame marker, checksum width.
// Purely declarative; no logic, no latency, no flow control.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         CSUM_W       = 8;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted payload bytes little-endian into a 32-bit word; word_valid_o pulses the cycle after the 4th byte.
// No backpressure of its own: the parent only strobes byte_vld_i on an accepted payload byte.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        last_byte_o
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_vld;

  // Shifting in from the top leaves the first byte in [7:0] after four bytes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= byte_vld_i && (r_cnt == 2'd3) && !clr_i;
      if (clr_i) begin
        r_word <= '0;
        r_cnt  <= '0;
      end else if (byte_vld_i) begin
        r_word <= {byte_i, r_word[31:8]};
        r_cnt  <= r_cnt + 2'd1;
      end
    end
  end

  assign word_o       = r_word;
  assign word_valid_o = r_vld;
  assign last_byte_o  = (r_cnt == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Parses an A5/len/payload/xor-checksum frame into IMEM and holds the core in reset until it verifies.
// IMEM write one cycle after a word's 4th byte; byte_ready_o drops during WRITE, DONE and ERROR.
module boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [15:0]         r_len;
  logic [ADDR_W:0]     r_idx;
  logic [CSUM_W-1:0]   r_csum;
  logic                r_rdy;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_core_rst_n;

  logic                w_acc;
  logic                w_rearm;
  logic [15:0]         w_len_full;
  logic [ADDR_W:0]     w_idx_nxt;
  logic                w_word_last;
  logic                w_word_vld;
  logic [31:0]         w_word;
  logic                w_rdy_d;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_err_d;
  logic                w_core_rst_n_d;

  assign w_acc      = byte_valid_i && r_rdy;
  assign w_rearm    = start_i && ((r_state == ST_DONE) || (r_state == ST_ERROR));
  assign w_len_full = {byte_i, r_len[7:0]};
  assign w_idx_nxt  = r_idx + {{ADDR_W{1'b0}}, 1'b1};

  word_assembler u_word_assembler (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (w_rearm),
    .byte_vld_i   (w_acc && (r_state == ST_DATA)),
    .byte_i       (byte_i),
    .word_o       (w_word),
    .word_valid_o (w_word_vld),
    .last_byte_o  (w_word_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_rdy        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rdy        <= w_rdy_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
      r_core_rst_n <= w_core_rst_n_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_acc && (byte_i == HDR_BYTE)) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (w_acc) w_state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_acc) begin
          if ({1'b0, w_len_full} > MAX_LEN) w_state_nxt = ST_ERROR;
          else if (w_len_full == 16'd0)     w_state_nxt = ST_CHECK;
          else                              w_state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (w_acc && w_word_last) w_state_nxt = ST_WRITE;
      ST_WRITE:  w_state_nxt = (16'(w_idx_nxt) == r_len) ? ST_CHECK : ST_DATA;
      ST_CHECK:  if (w_acc) w_state_nxt = (byte_i == r_csum) ? ST_DONE : ST_ERROR;
      ST_DONE:   if (start_i) w_state_nxt = ST_IDLE;
      ST_ERROR:  if (start_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from the next state so the registered flags line up with the state they describe.
  always_comb begin
    w_rdy_d        = 1'b0;
    w_busy_d       = 1'b1;
    w_done_d       = 1'b0;
    w_err_d        = 1'b0;
    w_core_rst_n_d = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_rdy_d  = 1'b1;
        w_busy_d = 1'b0;
      end
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: w_rdy_d = 1'b1;
      ST_DONE: begin
        w_busy_d       = 1'b0;
        w_done_d       = 1'b1;
        w_core_rst_n_d = 1'b1;
      end
      ST_ERROR: begin
        w_busy_d = 1'b0;
        w_err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_csum <= '0;
    end else if (w_rearm) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_csum <= '0;
    end else begin
      case (r_state)
        ST_LEN_LO: if (w_acc) r_len[7:0]  <= byte_i;
        ST_LEN_HI: if (w_acc) r_len[15:8] <= byte_i;
        ST_DATA:   if (w_acc) r_csum      <= r_csum ^ byte_i;
        ST_WRITE:  r_idx <= w_idx_nxt;
        default: ;
      endcase
    end
  end

  assign byte_ready_o = r_rdy;
  assign imem_we_o    = w_word_vld;
  assign imem_addr_o  = r_idx[ADDR_W-1:0];
  assign imem_wdata_o = w_word;
  assign core_rst_no  = r_core_rst_n;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed frame stimulus for boot_loader; expected IMEM writes are queued as frames are driven
// and checked against each write strobe seen on the falling edge.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bdat = 8'h00;
  logic        bvalid = 1'b0;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        core_rst_no;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(10), .HDR_BYTE(8'hA5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .byte_i       (bdat),
    .byte_valid_i (bvalid),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_no  (core_rst_no),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          base = 0;
  bit          rnd_gaps = 1'b0;
  logic [41:0] exp_q[$];
  logic [31:0] words[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every clock advance goes through here so no write strobe goes unchecked.
  task automatic tick();
    logic [41:0] e;
    @(negedge clk);
    if (imem_we_o) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(imem_we_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr_o), 64'(e[41:32]));
        chk("wr_data", 64'(imem_wdata_o), 64'(e[31:0]));
        chk("rdy_in_write", 64'(byte_ready_o), 64'd0);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (rnd_gaps) repeat ($urandom_range(0, 2)) tick();
    bdat   = b;
    bvalid = 1'b1;
    while (!byte_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 64'(byte_ready_o), 64'd1);
    tick();
    bvalid = 1'b0;
  endtask

  task automatic send_frame(input bit bad_csum);
    logic [7:0]  cs = 8'h00;
    logic [7:0]  b;
    logic [31:0] w;
    logic [15:0] len = 16'(words.size());
    for (int i = 0; i < words.size(); i++) exp_q.push_back({10'(i), words[i]});
    send_byte(8'hA5);
    chk("core_rst_during_load", 64'(core_rst_no), 64'd0);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        send_byte(b);
      end
      chk("we_after_4th", 64'(imem_we_o), 64'd1);
    end
    send_byte(bad_csum ? 8'hFF : cs);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_end(input string tag, input int nwr);
    chk({tag, "_writes"}, 64'(wr_seen - base), 64'(nwr));
    chk({tag, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs",
           64'({imem_we_o, imem_addr_o, imem_wdata_o, core_rst_no, busy_o, done_o, err_o, byte_ready_o}),
           64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Happy path: payload XOR of the two words is B0.
    base = wr_seen;
    words.delete();
    words.push_back(32'h00100513);
    words.push_back(32'h00200593);
    send_frame(1'b0);
    chk("happy_done", 64'(done_o), 64'd1);
    chk("happy_core_rst_n", 64'(core_rst_no), 64'd1);
    chk("happy_err", 64'(err_o), 64'd0);
    chk("happy_busy", 64'(busy_o), 64'd0);
    chk("happy_ready_in_done", 64'(byte_ready_o), 64'd0);
    chk_end("happy", 2);

    pulse_start();
    chk("rearm_done_clr", 64'(done_o), 64'd0);
    chk("rearm_core_rst", 64'(core_rst_no), 64'd0);

    // Bad checksum: writes still happen, error sticks until start.
    base = wr_seen;
    send_frame(1'b1);
    chk("bad_err", 64'(err_o), 64'd1);
    chk("bad_core_rst", 64'(core_rst_no), 64'd0);
    chk("bad_done", 64'(done_o), 64'd0);
    chk_end("bad", 2);
    tick();
    tick();
    chk("err_sticky", 64'(err_o), 64'd1);
    pulse_start();
    chk("err_cleared", 64'(err_o), 64'd0);
    chk("err_to_idle_ready", 64'(byte_ready_o), 64'd1);

    // Oversize length 1025.
    base = wr_seen;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    chk("oversize_err", 64'(err_o), 64'd1);
    chk_end("oversize", 0);
    pulse_start();

    // Zero length.
    base = wr_seen;
    words.delete();
    send_frame(1'b0);
    chk("zero_done", 64'(done_o), 64'd1);
    chk_end("zero", 0);
    pulse_start();

    // Full capacity: len == 2**ADDR_W must be accepted and fill every address.
    base = wr_seen;
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back(32'(i) * 32'h9E3779B1);
    send_frame(1'b0);
    chk("full_done", 64'(done_o), 64'd1);
    chk("full_err", 64'(err_o), 64'd0);
    chk_end("full", 1024);
    pulse_start();

    // Preamble garbage with random valid gaps.
    base = wr_seen;
    rnd_gaps = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    chk("garbage_busy", 64'(busy_o), 64'd0);
    words.delete();
    words.push_back(32'hCAFEF00D);
    send_frame(1'b0);
    rnd_gaps = 1'b0;
    chk("garbage_done", 64'(done_o), 64'd1);
    chk_end("garbage", 1);
    pulse_start();

    // Reset after two payload bytes, then a clean reload from address 0.
    base = wr_seen;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1 chk("midreset_outputs",
           64'({imem_we_o, imem_addr_o, imem_wdata_o, core_rst_no, busy_o, done_o, err_o, byte_ready_o}),
           64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    words.delete();
    words.push_back(32'h11223344);
    send_frame(1'b0);
    chk("midreset_done", 64'(done_o), 64'd1);
    chk_end("midreset", 1);

    // Re-arm and overwrite from address 0.
    pulse_start();
    chk("rearm2_core_rst", 64'(core_rst_no), 64'd0);
    base = wr_seen;
    words.delete();
    words.push_back(32'h00000093);
    words.push_back(32'hFFF00113);
    words.push_back(32'h0020A023);
    send_frame(1'b0);
    chk("rearm2_done", 64'(done_o), 64'd1);
    chk("rearm2_core_rst_n", 64'(core_rst_no), 64'd1);
    chk_end("rearm2", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
